pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 24-bit ASIP datapath (16-bit PC, 16×24-bit register file, R15 reads the PC).
- Keeps a register scoreboard of in-flight writes and stalls fetch/decode on RAW/WAW hazards.
- Flushes wrong-path instructions when execute resolves a taken branch (PCSrcE).
- Sits beside the datapath: drives the PC-register enable, decode-register enable and the decode/execute bubble controls.

Parameters:
- FLUSH_CYCLES, 2, number of cycles decode is squashed after a taken branch (1..15).
- NUM_REGS, 16, scoreboard depth; register addresses are 4 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- decValid  in  1  decode stage holds a real instruction
- decRa1  in  4  first source register (inst[15:12])
- decRa2  in  4  second source register (after the ra2Src mux)
- decUsesRa2  in  1  instruction reads decRa2
- decRegWrite  in  1  instruction will write decWa3
- decWa3  in  4  destination register (inst[19:16])
- PCSrcE  in  1  taken branch/PC write resolved in execute
- regWriteW  in  1  writeback stage writes WA3W this cycle
- WA3W  in  4  writeback destination
- stallF  out  1  hold PC register
- stallD  out  1  hold decode pipeline register
- flushD  out  1  clear decode register (wrong-path instruction)
- flushE  out  1  inject bubble into execute (regWriteE/memWriteE/PCSrcE forced 0)
- busyMask  out  16  current scoreboard (bit n = register n has a pending write)
- issue  out  1  decode instruction advances to execute this cycle

Behaviour:
- State machine RUN / FLUSH, registered. Reset: state=RUN, busyMask=0, flush counter=0; all outputs 0 while rst is high.
- hazard (combinational, RUN only) = decValid && ((busy[decRa1] && decRa1!=15) || (decUsesRa2 && busy[decRa2] && decRa2!=15) || (decRegWrite && busy[decWa3])).
- RUN, no PCSrcE: stallF=stallD=flushE=hazard; issue=decValid && !hazard; flushD=0.
- RUN, PCSrcE=1: PCSrcE has priority over hazard. stallF=stallD=0, flushD=flushE=1, issue=0. Next state FLUSH, counter loaded with FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN.
- FLUSH: flushD=flushE=1, stalls 0, issue=0, decValid ignored. Counter decrements; at 0, return to RUN next cycle. PCSrcE during FLUSH reloads the counter.
- Scoreboard update each edge:
  - clear busy[WA3W] if regWriteW;
  - set busy[decWa3] if issue && decRegWrite;
  - if set and clear hit the same register in one cycle, set wins.
- No same-cycle bypass: a clear is visible to hazard only from the next cycle, so a dependent instruction stalls until the cycle after writeback.
- Writes to R15 are tracked for WAW; reads of R15 never stall.
- regWriteW to a non-busy register: no effect, no error.
- Reset mid-flush or mid-stall returns to RUN with an empty scoreboard immediately (asynchronous).

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined: adds outputs stallCount[15:0] and flushCount[15:0].
  - Saturating counters incremented on each cycle with stallD=1 (hazard) or flushD=1 respectively.
  - Cleared by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - typedef enum logic {RUN, FLUSH} hz_state_t;
  - constants REG_PC=4'd15, NUM_REGS=16, REG_AW=4.
- One sub-module, hz_scoreboard: busy-bit array with set/clear ports and set-wins priority.
- FSM, hazard logic and counters stay in the top module.

Test Plan:
- Issue R3 write (decRegWrite=1, decWa3=3). Next cycle decode reads decRa1=3 -> stallF=stallD=flushE=1, busyMask=0x0008. regWriteW=1, WA3W=3 -> stall drops the following cycle, issue=1.
- PCSrcE=1 in RUN with FLUSH_CYCLES=2 -> flushD=flushE=1 for exactly 2 cycles, then RUN; decValid during that window produces no issue and no busy bit.
- Same cycle: issue writing R5 and regWriteW with WA3W=5 -> busyMask bit 5 remains 1.
- decRa1=15 with busy[15]=1 -> no stall. decRegWrite with decWa3=15 while busy[15]=1 -> stall (WAW).
- Hazard and PCSrcE in the same cycle -> stalls 0, flushes 1, state FLUSH.
- Assert rst during FLUSH with busyMask=0x00F0 -> outputs 0 and busyMask=0 immediately; RUN after release. With HAZ_STATS_EN, stallCount saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {RUN, FLUSH} hz_state_t;

  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam logic [REG_AW-1:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle; stats ports present only with HAZ_STATS_EN.
interface pipe_hazard_ctrl_if;
  import hazard_pkg::*;

  logic                decValid;
  logic [REG_AW-1:0]   decRa1;
  logic [REG_AW-1:0]   decRa2;
  logic                decUsesRa2;
  logic                decRegWrite;
  logic [REG_AW-1:0]   decWa3;
  logic                PCSrcE;
  logic                regWriteW;
  logic [REG_AW-1:0]   WA3W;
  logic                stallF;
  logic                stallD;
  logic                flushD;
  logic                flushE;
  logic [NUM_REGS-1:0] busyMask;
  logic                issue;
`ifdef HAZ_STATS_EN
  logic [15:0]         stallCount;
  logic [15:0]         flushCount;
`endif

  modport master (
    output decValid, decRa1, decRa2, decUsesRa2, decRegWrite, decWa3,
    output PCSrcE, regWriteW, WA3W,
`ifdef HAZ_STATS_EN
    input  stallCount, flushCount,
`endif
    input  stallF, stallD, flushD, flushE, busyMask, issue
  );

  modport slave (
    input  decValid, decRa1, decRa2, decUsesRa2, decRegWrite, decWa3,
    input  PCSrcE, regWriteW, WA3W,
`ifdef HAZ_STATS_EN
    output stallCount, flushCount,
`endif
    output stallF, stallD, flushD, flushE, busyMask, issue
  );

endinterface

// File: rtl/hz_scoreboard.sv
// Pending-write busy bits; a set and clear of the same register in one cycle leaves it busy.
module hz_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = hazard_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_i,
  input  logic [REG_AW-1:0]   set_addr_i,
  input  logic                clr_i,
  input  logic [REG_AW-1:0]   clr_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_i) set_mask = NUM_REGS'(1) << set_addr_i;
    if (clr_i) clr_mask = NUM_REGS'(1) << clr_addr_i;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: scoreboard RAW/WAW stalls and taken-branch flush.
// Optional HAZ_STATS_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned NUM_REGS     = hazard_pkg::NUM_REGS
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int unsigned     CNT_W  = 4;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_t           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REGS-1:0] busy;
  logic                hazard_c;
  logic                stall_c, flush_d_c, flush_e_c, issue_c;

  hz_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_i      (issue_c && bus.decRegWrite),
    .set_addr_i (bus.decWa3),
    .clr_i      (bus.regWriteW),
    .clr_addr_i (bus.WA3W),
    .busy_o     (busy)
  );

  // R15 reads return the PC, so only its write is tracked.
  always_comb begin
    hazard_c = bus.decValid &&
               ((busy[bus.decRa1] && (bus.decRa1 != REG_PC)) ||
                (bus.decUsesRa2 && busy[bus.decRa2] && (bus.decRa2 != REG_PC)) ||
                (bus.decRegWrite && busy[bus.decWa3]));
  end

  always_comb begin
    stall_c   = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    issue_c   = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (bus.PCSrcE) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
          end else begin
            stall_c   = hazard_c;
            flush_e_c = hazard_c;
            issue_c   = bus.decValid && !hazard_c;
          end
        end
        FLUSH: begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Flush window = the resolving RUN cycle plus FLUSH_CYCLES-1 FLUSH cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.PCSrcE && (FLUSH_CYCLES > 1)) begin
            state_q <= FLUSH;
            cnt_q   <= RELOAD;
          end
        end
        FLUSH: begin
          if (bus.PCSrcE) begin
            cnt_q <= RELOAD;
          end else if (cnt_q <= CNT_W'(1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.stallF   = stall_c;
  assign bus.stallD   = stall_c;
  assign bus.flushD   = flush_d_c;
  assign bus.flushE   = flush_e_c;
  assign bus.issue    = issue_c;
  assign bus.busyMask = busy;

`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_d_c && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.stallCount = stall_cnt_q;
  assign bus.flushCount = flush_cnt_q;
`endif

endmodule
